// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit MIPS core: fetch FSM states,
// instruction field positions and the opcode map used by decode/control.
package cpu_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_OR   = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_LW   = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_SW   = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 3'b111;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/cpu_ifid_skid.sv
// IF/ID pipeline register backed by a one-entry skid buffer. The skid absorbs
// the single response that can land while decode is stalled on a live entry.
module cpu_ifid_skid
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_stall,
  input  logic               i_in_valid,
  input  logic [INSTR_W-1:0] i_in_instr,
  input  logic [INSTR_W-1:0] i_in_pc_plus2,
  output logic               o_skid_full,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_pc_plus2
);

  logic               r_ifid_valid;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [INSTR_W-1:0] r_ifid_pc2;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [INSTR_W-1:0] r_skid_pc2;
  logic               w_ifid_open;

  // IF/ID may take a new entry when empty or when decode consumes it this cycle.
  assign w_ifid_open = !r_ifid_valid || !i_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc2   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc2   <= '0;
    end else if (i_flush) begin
      r_ifid_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_ifid_open) begin
      if (r_skid_valid) begin
        // Skid is older than anything arriving now, so it goes first.
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= r_skid_instr;
        r_ifid_pc2   <= r_skid_pc2;
        r_skid_valid <= i_in_valid;
        if (i_in_valid) begin
          r_skid_instr <= i_in_instr;
          r_skid_pc2   <= i_in_pc_plus2;
        end
      end else begin
        r_ifid_valid <= i_in_valid;
        if (i_in_valid) begin
          r_ifid_instr <= i_in_instr;
          r_ifid_pc2   <= i_in_pc_plus2;
        end
      end
    end else if (i_in_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= i_in_instr;
      r_skid_pc2   <= i_in_pc_plus2;
    end
  end

  assign o_skid_full = r_skid_valid;
  assign o_valid     = r_ifid_valid;
  assign o_instr     = r_ifid_instr;
  assign o_pc_plus2  = r_ifid_pc2;

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem request FSM with redirect
// draining, feeding the IF/ID register and skid buffer.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [15:0]         imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic                imem_rvalid,
  input  logic                id_stall,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  output logic                if_valid,
  output logic [15:0]         if_instr,
  output logic [15:0]         if_pc_plus2,
  output logic [OPCODE_W-1:0] if_opcode
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [15:0]  r_pc;
  logic [15:0]  w_pc_next;
  logic [15:0]  w_pc_inc;
  logic         w_issue;
  logic         w_capture;
  logic         w_skid_full;

  assign w_pc_inc = r_pc + PC_STEP;

  // A redirect suppresses the issue so no stale-address request is left in flight.
  assign w_issue   = rst_n && (r_state == REQ) && !w_skid_full && !redirect_valid;
  assign w_capture = (r_state == WAIT) && imem_rvalid && !redirect_valid;

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (redirect_valid) begin
      w_pc_next = redirect_pc;
      // A request still in flight (WAIT, or an earlier DRAIN) must be drained.
      if ((r_state != REQ) && !imem_rvalid) begin
        w_state_next = DRAIN;
      end else begin
        w_state_next = REQ;
      end
    end else begin
      case (r_state)
        REQ: begin
          if (w_issue) begin
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            w_pc_next    = w_pc_inc;
            w_state_next = REQ;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            w_state_next = REQ;
          end
        end
        default: w_state_next = REQ;
      endcase
    end
  end

  cpu_ifid_skid u_ifid_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (redirect_valid),
    .i_stall       (id_stall),
    .i_in_valid    (w_capture),
    .i_in_instr    (imem_rdata),
    .i_in_pc_plus2 (w_pc_inc),
    .o_skid_full   (w_skid_full),
    .o_valid       (if_valid),
    .o_instr       (if_instr),
    .o_pc_plus2    (if_pc_plus2)
  );

  assign if_opcode = get_opcode(if_instr);

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: memory model, retire scoreboard,
// a cycle table for the start-up/stall sequence and redirect/wrap/reset cases.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_rvalid = 1'b0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic [2:0]  if_opcode;

  always #5 clk = ~clk;

  cpu_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc_plus2    (if_pc_plus2),
    .if_opcode      (if_opcode)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        stall;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] instr;
    logic [15:0] pc2;
  } vec_t;
  vec_t tbl [16];

  // memory model state
  int          mem_lat = 1;
  bit          pend = 0;
  bit          pend_wrong = 0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0;
  bit          req_new = 0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] last_req_addr = 16'h0;
  logic [15:0] resp_addr = 16'h0;
  bit          resp_wrong = 0;
  bit          stray_next = 0;
  int          dead_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Negedge: scoreboard retire check, expected-queue upkeep, request capture.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    req_new = 0;
    if (!rst_n) begin
      exp_q.delete();
      pend = 0;
    end else begin
      if (if_valid && if_instr == 16'hDEAD) dead_seen++;
      if (if_valid && !id_stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: if_valid=1 instr=%h, required no live instruction", if_instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", {16'h0, if_instr}, {16'h0, e.instr});
          chk("sb_pc_plus2", {16'h0, if_pc_plus2}, {16'h0, e.pc2});
          chk("sb_opcode", {29'h0, if_opcode}, {29'h0, e.instr[15:13]});
          $display("[TB] retire instr=%h pc_plus2=%h opcode=%0d", if_instr, if_pc_plus2, if_opcode);
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        if (pend) pend_wrong = 1;
      end
      if (imem_rvalid && !redirect_valid && !resp_wrong) begin
        e.instr = imem_rdata;
        e.pc2   = resp_addr + 16'd2;
        exp_q.push_back(e);
      end
      if (imem_req) begin
        if (pend) begin
          n_tests++;
          n_fail++;
          $display("FAIL one_outstanding: imem_req at %h with %h still pending", imem_addr, pend_addr);
        end
        req_new = 1;
        req_addr = imem_addr;
        last_req_addr = imem_addr;
      end
    end
  endtask

  // Posedge+1: memory drives the response for this cycle.
  task automatic advance();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    resp_wrong  = 0;
    if (req_new) begin
      pend = 1;
      pend_addr = req_addr;
      pend_cnt = mem_lat;
      pend_wrong = 0;
    end
    if (stray_next) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hBAD0;
      resp_wrong  = 1;
      stray_next  = 0;
    end else if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_wrong ? 16'hDEAD : pend_addr;
        resp_addr   = pend_addr;
        resp_wrong  = pend_wrong;
        pend = 0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      advance();
    end
  endtask

  task automatic wait_req(input string name, output logic [15:0] a, output int cyc);
    a = 16'h0;
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      sample();
      if (imem_req) begin
        a = imem_addr;
        cyc = i;
        advance();
        return;
      end
      advance();
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: no imem_req within 30 cycles", name);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    {31'h0, imem_req}, 32'h0);
    chk({tag, "_addr"},   {16'h0, imem_addr}, 32'h0000);
    chk({tag, "_valid"},  {31'h0, if_valid}, 32'h0);
    chk({tag, "_instr"},  {16'h0, if_instr}, 32'h0);
    chk({tag, "_pc2"},    {16'h0, if_pc_plus2}, 32'h0);
    chk({tag, "_opcode"}, {29'h0, if_opcode}, 32'h0);
  endtask

  initial begin
    logic [15:0] a;
    int          cyc;
    bit          found;

    // cycle-by-cycle after reset release, memory latency 1, stall c6..c11
    tbl[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h0002};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0002};
    tbl[4]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'h0004};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 16'h0004};
    tbl[6]  = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'h0006};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0006};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0006};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0006};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0006};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0006};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h0006};
    tbl[13] = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0006, 16'h0008};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 16'h0008};
    tbl[15] = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h0008, 16'h000A};

    // reset
    rst_n = 1'b0;
    run(3);
    sample();
    chk_reset_outputs("reset");
    advance();
    rst_n = 1'b1;

    // table: sequential fetch and a 6-cycle stall with skid hand-off
    for (int i = 0; i < 16; i++) begin
      id_stall = tbl[i].stall;
      sample();
      chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), {16'h0, imem_addr}, {16'h0, tbl[i].addr});
      chk($sformatf("tbl%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].vld});
      chk($sformatf("tbl%0d_instr", i), {16'h0, if_instr}, {16'h0, tbl[i].instr});
      chk($sformatf("tbl%0d_pc2", i), {16'h0, if_pc_plus2}, {16'h0, tbl[i].pc2});
      $display("[TB] tbl%0d stall=%0b req=%0b addr=%h valid=%0b instr=%h", i, id_stall, imem_req, imem_addr, if_valid, if_instr);
      advance();
    end
    id_stall = 1'b0;

    // redirect in WAIT; wrong-path data 0xDEAD arrives 3 cycles later
    mem_lat = 4;
    wait_req("redir_wait_req", a, cyc);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    sample();
    advance();
    redirect_valid = 1'b0;
    mem_lat = 1;
    wait_req("redir_refetch", a, cyc);
    chk("redir_next_addr", {16'h0, a}, 32'h0040);
    chk("redir_drain_cycles", cyc, 4);
    run(8);
    chk("redir_no_dead", dead_seen, 0);

    // redirect in the same cycle as a response
    wait_req("same_cycle_req", a, cyc);
    redirect_valid = 1'b1;
    redirect_pc = 16'hA000;
    sample();
    advance();
    redirect_valid = 1'b0;
    sample();
    chk("same_cycle_valid", {31'h0, if_valid}, 32'h0);
    chk("same_cycle_req", {31'h0, imem_req}, 32'h1);
    chk("same_cycle_addr", {16'h0, imem_addr}, 32'hA000);
    advance();
    run(6);

    // wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFC;
    sample();
    advance();
    redirect_valid = 1'b0;
    wait_req("wrap_first", a, cyc);
    chk("wrap_first_addr", {16'h0, a}, 32'hFFFC);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      sample();
      if (if_valid && if_instr == 16'hFFFE) begin
        found = 1;
        chk("wrap_pc_plus2", {16'h0, if_pc_plus2}, 32'h0000);
        chk("wrap_opcode", {29'h0, if_opcode}, 32'h7);
        chk("wrap_next_addr", {16'h0, last_req_addr}, 32'h0000);
      end
      advance();
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL wrap_seen: instruction FFFE never became valid within 12 cycles");
    end
    run(4);

    // reset while in WAIT, stray response in the first cycle after release
    mem_lat = 3;
    wait_req("rst_wait_req", a, cyc);
    rst_n = 1'b0;
    sample();
    advance();
    sample();
    chk_reset_outputs("midreset");
    stray_next = 1;
    advance();
    rst_n = 1'b1;
    sample();
    chk("post_reset_req", {31'h0, imem_req}, 32'h1);
    chk("post_reset_addr", {16'h0, imem_addr}, 32'h0000);
    chk("post_reset_valid", {31'h0, if_valid}, 32'h0);
    chk("post_reset_instr", {16'h0, if_instr}, 32'h0);
    chk("post_reset_pc2", {16'h0, if_pc_plus2}, 32'h0);
    advance();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      sample();
      if (if_valid) begin
        found = 1;
        chk("post_reset_first_instr", {16'h0, if_instr}, 32'h0000);
        chk("post_reset_first_pc2", {16'h0, if_pc_plus2}, 32'h0002);
      end
      advance();
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL post_reset_fetch: no valid instruction within 10 cycles after reset");
    end
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
Instruction fetch stage and IF/ID pipeline register for the 16-bit MIPS processor.
- Owns the PC and drives a one-outstanding request/response interface to instruction memory.
- Presents the fetched instruction, with a valid flag and the decoded opcode field, to the decode stage and the control unit.
- Handles stalls from decode and PC redirects (jump/branch) from execute, including discarding in-flight wrong-path fetches.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 2, byte increment between sequential instructions.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
imem_req  out  1  one-cycle fetch request strobe
imem_addr  out  16  fetch address, valid while imem_req=1
imem_rdata  in  16  instruction word, valid with imem_rvalid
imem_rvalid  in  1  response strobe, at least 1 cycle after imem_req
id_stall  in  1  decode cannot accept; hold IF/ID
redirect_valid  in  1  jump/branch taken; flush and refetch
redirect_pc  in  16  new fetch address
if_valid  out  1  IF/ID holds a live instruction
if_instr  out  16  IF/ID instruction word
if_pc_plus2  out  16  fetch address + PC_STEP of the held instruction
if_opcode  out  3  if_instr[15:13], feeds control unit cpu_opcode

Behaviour:
- Reset (rst_n=0 at clk edge) sets:
  - pc=RESET_PC; state=REQ.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=16'h0000, if_pc_plus2=0.
  - skid buffer empty.
  - Reset mid-fetch drops any outstanding response; an rvalid in the first cycle after reset is ignored.
- State machine, 3 states:
  - REQ: if a slot is free (skid empty), assert imem_req=1 with imem_addr=pc, then go to WAIT. Otherwise stay in REQ with imem_req=0.
  - WAIT: wait for imem_rvalid. On rvalid, pc<=pc+PC_STEP and go to REQ.
  - DRAIN: a redirect occurred while in WAIT. Ignore the data of the next rvalid, then go to REQ.
- Request/response rules:
  - At most one outstanding request; imem_req is never asserted outside REQ.
  - Minimum issue-to-issue interval is 2 cycles (REQ, WAIT with rvalid).
- Capture:
  - On rvalid in WAIT, the word and its pc+PC_STEP go to IF/ID if (!if_valid || !id_stall); otherwise they go to the 1-entry skid buffer.
  - When the stall releases and the skid is full, the skid moves to IF/ID that cycle and the skid empties.
- Advance:
  - If if_valid && !id_stall and nothing new is available, if_valid<=0 next cycle (bubble).
  - IF/ID is never overwritten while if_valid && id_stall.
- Redirect (highest priority, any state):
  - pc<=redirect_pc; if_valid<=0; skid cleared.
  - If state=WAIT with no rvalid this cycle, go to DRAIN; otherwise go to REQ.
  - A response arriving in the same cycle as the redirect is discarded.
  - Redirect combined with id_stall still flushes.
- Width and arithmetic:
  - PC addition is modulo 2^16; 16'hFFFE + 2 wraps to 16'h0000 silently.
- Output decode:
  - if_opcode is combinational from if_instr.
  - When if_valid=0, downstream must treat the instruction as a bubble. The control unit decodes 000 as a reg-writing add, so the top level gates cpu_reg_wr and cpu_mem_wr with if_valid.
- No combinational path from imem_rdata or imem_rvalid to imem_req.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {REQ, WAIT, DRAIN}.
  - Constants INSTR_W=16, OPCODE_MSB=15, OPCODE_LSB=13.
  - opcode localparams (OP_ADD=3'b000 … OP_ADDI=3'b111), shared with the control unit.
- One sub-module: cpu_ifid_skid, the IF/ID register plus 1-entry skid buffer with stall/flush. The fetch FSM and PC live in cpu_fetch_unit.

Test Plan:
- Reset, memory returning instruction = address, 1-cycle latency:
  - Requests at 0x0000, 0x0002, 0x0004 every 2 cycles.
  - if_instr follows 0x0000, 0x0002…; if_pc_plus2 follows 0x0002, 0x0004….
- id_stall held 6 cycles while if_valid=1:
  - IF/ID frozen; at most one further request issues, and its response lands in skid.
  - On release, IF/ID = skid word next cycle, with no lost or duplicated instruction.
- redirect_pc=0x0040 while in WAIT, rvalid 3 cycles later with 0xDEAD:
  - 0xDEAD never appears with if_valid=1.
  - Next imem_addr=0x0040.
- redirect_valid and imem_rvalid in the same cycle:
  - Response discarded, if_valid=0, next request at redirect_pc.
- Fetch near 0xFFFE: next imem_addr=0x0000, and if_pc_plus2=0x0000 for the 0xFFFE fetch.
- Assert rst_n=0 in WAIT, then issue a stray rvalid 1 cycle after release:
  - Stray response ignored, all outputs at reset values.
  - First request at RESET_PC.
